cfg_stream_sequencer: RTL and testbench



---
 rtl/cfg_seq_pkg.sv | 43 ++++
 rtl/cfg_stream_sequencer_tile_onehot_decoder.sv | 43 ++++
 rtl/cfg_stream_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_cfg_stream_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_seq_pkg.sv
// cfg_seq_pkg
//   Shared definitions for the configuration stream sequencer:
//   - cfg_seq_state_e : sequencer FSM states
//   - TERM_TILE_ID    : TILE byte value that ends a configuration stream
//   - DEF_*           : default widths / tile count used by the top level
//   - addr_hi_illegal : flags ADDR_HI bytes carrying bits beyond ADDR_W
package cfg_seq_pkg;

  localparam int unsigned DEF_NB_TILES = 16;
  localparam int unsigned DEF_ADDR_W   = 10;
  localparam int unsigned DEF_DATA_W   = 8;

  // Header fields are always byte-sized, whatever DATA_W is.
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned TILE_IDX_W   = 8;

  localparam logic [BYTE_W-1:0] TERM_TILE_ID = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    HDR_TILE,
    HDR_ALO,
    HDR_AHI,
    HDR_CNT,
    DATA,
    CHK,
    DONE,
    ERROR
  } cfg_seq_state_e;

  // ADDR_HI supplies address bits [ADDR_W-1:8]; any bit above that is illegal.
  function automatic logic addr_hi_illegal(input logic [BYTE_W-1:0] hi,
                                           input int unsigned        addr_w);
    logic illegal;
    if (addr_w >= 16) begin
      illegal = 1'b0;
    end else begin
      illegal = ((hi >> (addr_w - 8)) != '0);
    end
    return illegal;
  endfunction

endpackage

// File: rtl/cfg_stream_sequencer_tile_onehot_decoder.sv
// tile_onehot_decoder
//   Registered index-to-one-hot decoder. When enable is high the bit
//   selected by index is set in the following cycle, for one cycle only;
//   otherwise select is all zeros. An out-of-range index yields zero.
// Ports:
//   clock   in  rising-edge clock
//   reset   in  synchronous active-high reset (clears select)
//   enable  in  produce a strobe for index next cycle
//   index   in  tile index
//   select  out one-hot strobe, NB_TILES wide
module tile_onehot_decoder #(
  parameter int unsigned NB_TILES = 16,
  parameter int unsigned IDX_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [IDX_W-1:0]    index,
  output logic [NB_TILES-1:0] select
);

  logic [NB_TILES-1:0] onehot;

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NB_TILES; i++) begin
      if (32'(index) == i) begin
        onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      select <= '0;
    end else if (enable) begin
      select <= onehot;
    end else begin
      select <= '0;
    end
  end

endmodule

// File: rtl/cfg_stream_sequencer.sv
// cfg_stream_sequencer
//   Fabric configuration controller. Parses a byte stream of records
//   (TILE, ADDR_LO, ADDR_HI, CNT, then CNT+1 data bytes) and drives the
//   broadcast tile loader bus with one write per accepted data byte,
//   auto-incrementing the address. A TILE byte of 8'hFF ends the stream.
//
// Optional feature (macro CFG_SEQ_CHECKSUM_EN):
//   After the terminator one extra byte is accepted and compared with the
//   XOR of every stream byte since start (terminator included);
//   match -> DONE, mismatch -> ERROR. Without the macro the terminator
//   goes straight to DONE.
//
// Ports:
//   clock         in   configuration clock (rising edge)
//   reset         in   synchronous active-high reset
//   start         in   arms the sequencer from IDLE or DONE
//   cfg_valid     in   stream byte valid
//   cfg_ready     out  sequencer accepts a byte (HDR_*/DATA[/CHK])
//   cfg_data      in   stream byte
//   select_tile   out  one-hot write strobe, one cycle per write
//   address_tile  out  write address (holds when idle)
//   data_tile     out  write data (holds when idle)
//   busy          out  stream in progress
//   done          out  stream completed (level)
//   error         out  stream aborted on a bad record (level, until reset)
module cfg_stream_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int unsigned NB_TILES = DEF_NB_TILES,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [DATA_W-1:0]   cfg_data,
  output logic [NB_TILES-1:0] select_tile,
  output logic [ADDR_W-1:0]   address_tile,
  output logic [DATA_W-1:0]   data_tile,
  output logic                busy,
  output logic                done,
  output logic                error
);

  cfg_seq_state_e state, state_nxt;

  logic [TILE_IDX_W-1:0] tile_q, tile_nxt;
  logic [BYTE_W-1:0]     alo_q, alo_nxt;
  logic [BYTE_W-1:0]     remaining_q, remaining_nxt;
  logic [ADDR_W-1:0]     addr_q, addr_nxt;
  logic [ADDR_W-1:0]     address_nxt;
  logic [DATA_W-1:0]     data_nxt;
  logic                  wr_en;
  logic                  accept;
  logic [BYTE_W-1:0]     byte_in;

`ifdef CFG_SEQ_CHECKSUM_EN
  logic [BYTE_W-1:0]     xor_q, xor_nxt;
`endif

  assign byte_in = cfg_data[BYTE_W-1:0];

  always_comb begin
    state_nxt     = state;
    tile_nxt      = tile_q;
    alo_nxt       = alo_q;
    remaining_nxt = remaining_q;
    addr_nxt      = addr_q;
    address_nxt   = address_tile;
    data_nxt      = data_tile;
    wr_en         = 1'b0;

    unique case (state)
      HDR_TILE, HDR_ALO, HDR_AHI, HDR_CNT, DATA: cfg_ready = 1'b1;
`ifdef CFG_SEQ_CHECKSUM_EN
      CHK:                                       cfg_ready = 1'b1;
`endif
      default:                                   cfg_ready = 1'b0;
    endcase

    busy   = cfg_ready;
    done   = (state == DONE);
    error  = (state == ERROR);
    accept = cfg_valid & cfg_ready;

`ifdef CFG_SEQ_CHECKSUM_EN
    xor_nxt = xor_q;
    if (accept) begin
      xor_nxt = xor_q ^ byte_in;
    end
`endif

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = HDR_TILE;
`ifdef CFG_SEQ_CHECKSUM_EN
          xor_nxt   = '0;
`endif
        end
      end

      HDR_TILE: begin
        if (accept) begin
          if (byte_in == TERM_TILE_ID) begin
`ifdef CFG_SEQ_CHECKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = DONE;
`endif
          end else if (32'(byte_in) >= NB_TILES) begin
            state_nxt = ERROR;
          end else begin
            tile_nxt  = byte_in;
            state_nxt = HDR_ALO;
          end
        end
      end

      HDR_ALO: begin
        if (accept) begin
          alo_nxt   = byte_in;
          state_nxt = HDR_AHI;
        end
      end

      HDR_AHI: begin
        if (accept) begin
          if (addr_hi_illegal(byte_in, ADDR_W)) begin
            state_nxt = ERROR;
          end else begin
            addr_nxt  = ADDR_W'({byte_in, alo_q});
            state_nxt = HDR_CNT;
          end
        end
      end

      HDR_CNT: begin
        if (accept) begin
          remaining_nxt = byte_in;
          state_nxt     = DATA;
        end
      end

      DATA: begin
        if (accept) begin
          // The write is issued even when it is the one that runs off the
          // top of the address space; only the following increment errors.
          wr_en       = 1'b1;
          address_nxt = addr_q;
          data_nxt    = cfg_data;
          if (remaining_q == '0) begin
            state_nxt = HDR_TILE;
          end else if (addr_q == '1) begin
            state_nxt = ERROR;
          end else begin
            remaining_nxt = remaining_q - 1'b1;
            addr_nxt      = addr_q + 1'b1;
          end
        end
      end

`ifdef CFG_SEQ_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_nxt = (byte_in == xor_q) ? DONE : ERROR;
        end
      end
`endif

      ERROR: begin
        state_nxt = ERROR;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      tile_q       <= '0;
      alo_q        <= '0;
      remaining_q  <= '0;
      addr_q       <= '0;
      address_tile <= '0;
      data_tile    <= '0;
    end else begin
      state        <= state_nxt;
      tile_q       <= tile_nxt;
      alo_q        <= alo_nxt;
      remaining_q  <= remaining_nxt;
      addr_q       <= addr_nxt;
      address_tile <= address_nxt;
      data_tile    <= data_nxt;
    end
  end

`ifdef CFG_SEQ_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      xor_q <= '0;
    end else begin
      xor_q <= xor_nxt;
    end
  end
`endif

  // Strobe is registered alongside address/data so all three line up in
  // the cycle after the data byte is accepted.
  tile_onehot_decoder #(
    .NB_TILES (NB_TILES),
    .IDX_W    (TILE_IDX_W)
  ) u_select_dec (
    .clock  (clock),
    .reset  (reset),
    .enable (wr_en),
    .index  (tile_q),
    .select (select_tile)
  );

endmodule

// File: tb/tb_cfg_stream_sequencer.sv
// tb_cfg_stream_sequencer
//   Stream-level reference model: each stream is parsed up front into a
//   per-byte list of expected writes plus the final outcome; a compare
//   process checks every DUT output every cycle against that model.
module tb_cfg_stream_sequencer;

  localparam int unsigned NB_TILES = 16;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 8;
  localparam int          ADDR_MAX = (1 << ADDR_W) - 1;
  localparam int          HI_LIMIT = 1 << (ADDR_W - 8);

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [DATA_W-1:0]   cfg_data;
  logic [NB_TILES-1:0] select_tile;
  logic [ADDR_W-1:0]   address_tile;
  logic [DATA_W-1:0]   data_tile;
  logic                busy;
  logic                done;
  logic                error;

  always #5 clock = ~clock;

  cfg_stream_sequencer #(
    .NB_TILES (NB_TILES),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .select_tile  (select_tile),
    .address_tile (address_tile),
    .data_tile    (data_tile),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] strm[$];
  bit         ev_wr[$];
  int         ev_tile[$];
  int         ev_addr[$];
  int         ev_dat[$];
  int         n_used;
  bit         end_ok;
  int         pos;

  logic                exp_ready, exp_busy, exp_done, exp_err;
  logic [NB_TILES-1:0] exp_sel;
  logic [ADDR_W-1:0]   exp_addr;
  logic [DATA_W-1:0]   exp_data;

  bit                  chk_on = 1'b0;
  int                  n_strobes;
  logic [NB_TILES-1:0] last_sel;
  logic [ADDR_W-1:0]   last_addr;
  logic [DATA_W-1:0]   last_data;

  task automatic push_ev(input bit wr, input int t, input int a, input int d);
    ev_wr.push_back(wr);
    ev_tile.push_back(t);
    ev_addr.push_back(a);
    ev_dat.push_back(d);
  endtask

  // Walk the stream by the record rules and note, per consumed byte,
  // whether it is a write and where; stop at terminator or first fault.
  task automatic build_model();
    int i, t, lo, hi, cnt, addr;
    logic [7:0] acc;
    bit stop;
    ev_wr.delete(); ev_tile.delete(); ev_addr.delete(); ev_dat.delete();
    i = 0; acc = '0; stop = 1'b0; end_ok = 1'b0;
    while (!stop) begin
      t = int'(strm[i]); acc ^= strm[i]; push_ev(0, 0, 0, 0); i++;
      if (t == 255) begin
`ifdef CFG_SEQ_CHECKSUM_EN
        end_ok = (strm[i] == acc); push_ev(0, 0, 0, 0); i++;
`else
        end_ok = 1'b1;
`endif
        stop = 1'b1;
      end else if (t >= int'(NB_TILES)) begin
        stop = 1'b1;
      end else begin
        lo = int'(strm[i]); hi = int'(strm[i+1]);
        acc ^= strm[i] ^ strm[i+1];
        push_ev(0, 0, 0, 0); push_ev(0, 0, 0, 0); i += 2;
        if (hi >= HI_LIMIT) begin
          stop = 1'b1;
        end else begin
          addr = hi * 256 + lo;
          cnt = int'(strm[i]); acc ^= strm[i]; push_ev(0, 0, 0, 0); i++;
          for (int k = 0; k <= cnt && !stop; k++) begin
            acc ^= strm[i];
            push_ev(1, t, addr, int'(strm[i])); i++;
            if (k < cnt) begin
              if (addr == ADDR_MAX) stop = 1'b1;
              else addr++;
            end
          end
        end
      end
    end
    n_used = i;
  endtask

  // Advance one clock and update expectations from what the edge sampled.
  task automatic step();
    bit hs, rs;
    hs = cfg_valid && exp_ready;
    rs = reset;
    @(posedge clock); #1;
    exp_sel = '0;
    if (rs) begin
      exp_ready = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
      exp_addr = '0; exp_data = '0;
    end else if (hs) begin
      if (ev_wr[pos]) begin
        exp_sel  = NB_TILES'(1) << ev_tile[pos];
        exp_addr = ADDR_W'(ev_addr[pos]);
        exp_data = DATA_W'(ev_dat[pos]);
      end
      pos++;
      if (pos == n_used) begin
        exp_ready = 1'b0; exp_busy = 1'b0;
        exp_done = end_ok; exp_err = !end_ok;
      end
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      check("cfg_ready",    32'(cfg_ready),    32'(exp_ready));
      check("busy",         32'(busy),         32'(exp_busy));
      check("done",         32'(done),         32'(exp_done));
      check("error",        32'(error),        32'(exp_err));
      check("select_tile",  32'(select_tile),  32'(exp_sel));
      check("address_tile", 32'(address_tile), 32'(exp_addr));
      check("data_tile",    32'(data_tile),    32'(exp_data));
      if (select_tile != '0) begin
        n_strobes++;
        last_sel  = select_tile;
        last_addr = address_tile;
        last_data = data_tile;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; cfg_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic add_term(input bit good);
    logic [7:0] acc;
    acc = '0;
    strm.push_back(8'hFF);
`ifdef CFG_SEQ_CHECKSUM_EN
    foreach (strm[i]) acc ^= strm[i];
    strm.push_back(good ? acc : (acc ^ 8'h01));
`else
    if (good) acc = '0;
`endif
  endtask

  // vmode: 0 random valid, 1 valid always, 2 valid toggling
  task automatic run_stream(input int vmode);
    int cyc;
    build_model();
    n_strobes = 0;
    start = 1'b1; cfg_valid = 1'b0;
    step();
    start = 1'b0;
    exp_ready = 1'b1; exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    pos = 0; cyc = 0;
    while (pos < n_used && cyc < 4000) begin
      case (vmode)
        1:       cfg_valid = 1'b1;
        2:       cfg_valid = (cyc % 2 == 0);
        default: cfg_valid = ($urandom_range(0, 3) != 0);
      endcase
      cfg_data = (pos < strm.size()) ? strm[pos] : 8'($urandom);
      start = (vmode == 0) && ($urandom_range(0, 15) == 0);
      step();
      cyc++;
    end
    start = 1'b0;
    check("stream_consumed_in_budget", 32'(pos), 32'(n_used));
    repeat (3) begin
      cfg_valid = 1'b1; cfg_data = 8'($urandom);
      step();
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    exp_ready = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_sel = '0; exp_addr = '0; exp_data = '0;
    step();
    chk_on = 1'b1;
    reset = 1'b0;
    step();
    check("reset_select", 32'(select_tile), 32'h0);
    check("reset_ready",  32'(cfg_ready),   32'h0);
    check("reset_busy",   32'(busy),        32'h0);

    // single write
    strm = '{8'h03, 8'h10, 8'h00, 8'h00, 8'hA5};
    add_term(1);
    run_stream(1);
    check("single_strobes", 32'(n_strobes), 32'd1);
    check("single_sel",     32'(last_sel),   32'h0008);
    check("single_addr",    32'(last_addr),  32'h010);
    check("single_data",    32'(last_data),  32'hA5);
    check("single_done",    32'(done),       32'h1);
    check("single_busy",    32'(busy),       32'h0);

    // burst to the top of the address space, restarted from DONE
    strm = '{8'h01, 8'hFE, 8'h03, 8'h01, 8'h11, 8'h22};
    add_term(1);
    run_stream(1);
    check("burst_strobes", 32'(n_strobes), 32'd2);
    check("burst_addr",    32'(last_addr), 32'h3FF);
    check("burst_data",    32'(last_data), 32'h22);
    check("burst_error",   32'(error),     32'h0);

    strm = '{8'h01, 8'hFE, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33};
    add_term(1);
    run_stream(1);
    check("ovf_strobes", 32'(n_strobes), 32'd2);
    check("ovf_addr",    32'(last_addr), 32'h3FF);
    check("ovf_error",   32'(error),     32'h1);
    check("ovf_ready",   32'(cfg_ready), 32'h0);
    do_reset();

    // stalled burst
    strm = '{8'h05, 8'h00, 8'h01, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    add_term(1);
    run_stream(2);
    check("stall_strobes", 32'(n_strobes), 32'd4);
    check("stall_sel",     32'(last_sel),  32'h0020);
    check("stall_addr",    32'(last_addr), 32'h103);
    check("stall_data",    32'(last_data), 32'hA3);

    // illegal headers
    do_reset();
    strm = '{8'h10, 8'h00, 8'h00, 8'h00};
    run_stream(1);
    check("bad_tile_error", 32'(error),     32'h1);
    check("bad_tile_ready", 32'(cfg_ready), 32'h0);
    do_reset();
    strm = '{8'h00, 8'h00, 8'h04, 8'h00};
    run_stream(1);
    check("bad_ahi_error", 32'(error),     32'h1);
    check("bad_ahi_ready", 32'(cfg_ready), 32'h0);
    do_reset();

    // reset after two of four data bytes, then a clean record
    strm = '{8'h02, 8'h20, 8'h01, 8'h03, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
    add_term(1);
    build_model();
    start = 1'b1; step(); start = 1'b0;
    exp_ready = 1'b1; exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    pos = 0;
    for (int c = 0; c < 6; c++) begin
      cfg_valid = 1'b1; cfg_data = strm[pos];
      step();
    end
    reset = 1'b1; cfg_valid = 1'b1; cfg_data = strm[pos];
    step();
    reset = 1'b0; cfg_valid = 1'b0;
    check("midrst_select", 32'(select_tile),  32'h0);
    check("midrst_addr",   32'(address_tile), 32'h0);
    check("midrst_data",   32'(data_tile),    32'h0);
    check("midrst_busy",   32'(busy),         32'h0);
    step();
    strm = '{8'h07, 8'h33, 8'h00, 8'h00, 8'h5C};
    add_term(1);
    run_stream(1);
    check("after_rst_sel",  32'(last_sel),  32'h0080);
    check("after_rst_addr", 32'(last_addr), 32'h033);
    check("after_rst_data", 32'(last_data), 32'h5C);

`ifdef CFG_SEQ_CHECKSUM_EN
    strm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'hA5};
    run_stream(1);
    check("csum_good_done", 32'(done), 32'h1);
    strm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hFF, 8'hA4};
    run_stream(1);
    check("csum_bad_error", 32'(error), 32'h1);
    do_reset();
`endif

    // randomized streams
    for (int it = 0; it < 40; it++) begin
      int nrec, t, a, hi, cnt;
      if (exp_err) do_reset();
      strm.delete();
      nrec = $urandom_range(1, 3);
      for (int r = 0; r < nrec; r++) begin
        t = ($urandom_range(0, 19) == 0) ? $urandom_range(16, 250) : $urandom_range(0, 15);
        a = ($urandom_range(0, 3) == 0) ? ADDR_MAX - $urandom_range(0, 4)
                                        : $urandom_range(0, ADDR_MAX);
        hi = a >> 8;
        if ($urandom_range(0, 19) == 0) hi = hi | (4 << $urandom_range(0, 5));
        cnt = $urandom_range(0, 5);
        strm.push_back(8'(t));
        strm.push_back(8'(a));
        strm.push_back(8'(hi));
        strm.push_back(8'(cnt));
        for (int k = 0; k <= cnt; k++) strm.push_back(8'($urandom));
      end
      add_term($urandom_range(0, 4) != 0);
      run_stream(0);
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
